dmem_responder: RTL and testbench

- Memory-side responder for the hart data-memory port. It replaces the combinational dmem dummy with a realistic multi-cycle memory.
- Accepts one load or store request at a time, holds it for a fixed latency, applies byte-masked writes to internal word storage, and returns read data with a one-cycle valid pulse.
- Sits between the hart dmem outputs and storage. The pipelined hart stalls while o_busy is high.

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle data-memory responder with byte-masked word storage.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_addr,
   input  logic        i_ren,
   input  logic        i_wen,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_mask,
   output logic        o_busy,
   output logic        o_rvalid,
   output logic [31:0] o_rdata,
   output logic        o_error
);

   localparam int c_addr_w = $clog2(DEPTH_WORDS);
   localparam int c_cnt_w  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;
   logic [31:0]          addr_q, addr_d;
   logic                 ren_q, ren_d;
   logic                 wen_q, wen_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           mask_q, mask_d;
   logic                 busy_q, busy_d;
   logic                 rvalid_q, rvalid_d;
   logic                 error_q, error_d;
   logic [31:0]          rdata_q, rdata_d;

   logic [31:0]          mem_q [DEPTH_WORDS];

   logic                 w_accept;
   logic                 w_commit;
   logic [31:0]          w_src_addr;
   logic                 w_src_ren;
   logic                 w_src_wen;
   logic [31:0]          w_src_wdata;
   logic [3:0]           w_src_mask;
   logic [c_addr_w-1:0]  w_src_idx;
   logic                 w_src_err;
   logic                 w_mem_we;
   logic [31:0]          w_lane;
   logic                 w_unused_addr_bits;

   // RESP is a not-busy cycle, so a new request may be taken there too.
   assign w_accept = (state_q != S_WAIT) && (i_ren || i_wen);

   // With a single-cycle latency the request commits on the edge that accepts it,
   // so the live inputs are the source instead of the latched copy.
   assign w_src_addr  = (LATENCY == 1) ? i_addr  : addr_q;
   assign w_src_ren   = (LATENCY == 1) ? i_ren   : ren_q;
   assign w_src_wen   = (LATENCY == 1) ? i_wen   : wen_q;
   assign w_src_wdata = (LATENCY == 1) ? i_wdata : wdata_q;
   assign w_src_mask  = (LATENCY == 1) ? i_mask  : mask_q;

   assign w_src_idx          = w_src_addr[c_addr_w+1:2];
   assign w_unused_addr_bits = ^w_src_addr[1:0];
   assign w_src_err          = (w_src_ren && w_src_wen) ||
                               ((w_src_addr >> (c_addr_w + 2)) != 32'd0);

   assign w_commit = ((state_q == S_WAIT) && (cnt_q == c_cnt_w'(1))) ||
                     ((LATENCY == 1) && w_accept);
   assign w_mem_we = w_commit && w_src_wen && !w_src_err;
   assign w_lane   = {{8{w_src_mask[3]}}, {8{w_src_mask[2]}},
                      {8{w_src_mask[1]}}, {8{w_src_mask[0]}}};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      ren_d    = ren_q;
      wen_d    = wen_q;
      wdata_d  = wdata_q;
      mask_d   = mask_q;
      rdata_d  = rdata_q;
      error_d  = 1'b0;

      case (state_q)
         S_WAIT: begin
            if (cnt_q == c_cnt_w'(1)) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (w_accept) begin
               addr_d  = i_addr;
               ren_d   = i_ren;
               wen_d   = i_wen;
               wdata_d = i_wdata;
               mask_d  = i_mask;
               cnt_d   = c_cnt_w'(LATENCY - 1);
               state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
      endcase

      if (w_commit) begin
         error_d = w_src_err;
         if (w_src_err || w_src_wen) begin
            rdata_d = 32'd0;
         end else begin
            rdata_d = mem_q[w_src_idx] & w_lane;
         end
      end

      busy_d   = (state_d == S_WAIT);
      rvalid_d = (state_d == S_RESP);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
         mask_q   <= '0;
         busy_q   <= 1'b0;
         rvalid_q <= 1'b0;
         error_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         ren_q    <= ren_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
         mask_q   <= mask_d;
         busy_q   <= busy_d;
         rvalid_q <= rvalid_d;
         error_q  <= error_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage survives reset; an async reset mid-flight leaves the FSM idle so
   // the pending write never reaches this block.
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_src_mask[b]) begin
               mem_q[w_src_idx][8*b +: 8] <= w_src_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_busy   = busy_q;
   assign o_rvalid = rvalid_q;
   assign o_rdata  = rdata_q;
   assign o_error  = error_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Scoreboard bench for dmem_responder at LATENCY=2 and LATENCY=1.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        a_ren, a_wen, a_busy, a_rvalid, a_error;
   logic [3:0]  a_mask;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic        b_ren, b_wen, b_busy, b_rvalid, b_error;
   logic [3:0]  b_mask;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_addr(a_addr), .i_ren(a_ren), .i_wen(a_wen),
      .i_wdata(a_wdata), .i_mask(a_mask), .o_busy(a_busy), .o_rvalid(a_rvalid),
      .o_rdata(a_rdata), .o_error(a_error)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_addr(b_addr), .i_ren(b_ren), .i_wen(b_wen),
      .i_wdata(b_wdata), .i_mask(b_mask), .o_busy(b_busy), .o_rvalid(b_rvalid),
      .o_rdata(b_rdata), .o_error(b_error)
   );

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Scoreboard monitors: every response pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (a_rvalid === 1'b1) begin
         if (qa.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL a_unexpected_rvalid: got rvalid=1, expected none (t=%0t)", $time);
         end else begin
            e = qa.pop_front();
            chk("a_rdata", a_rdata, e.d);
            chk("a_error", {31'd0, a_error}, {31'd0, e.e});
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (b_rvalid === 1'b1) begin
         if (qb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL b_unexpected_rvalid: got rvalid=1, expected none (t=%0t)", $time);
         end else begin
            e = qb.pop_front();
            chk("b_rdata", b_rdata, e.d);
            chk("b_error", {31'd0, b_error}, {31'd0, e.e});
         end
      end
   end

   // Drive one request for a single cycle once dut_a is not busy; returns #1 after acceptance edge.
   task automatic req_a(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input logic [31:0] ed, input logic ee);
      int g = 0;
      while (a_busy && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 50) begin
         n_cmp++; n_fail++;
         $display("FAIL a_busy_timeout: got busy stuck, expected release");
      end
      a_ren = ren; a_wen = wen; a_addr = addr; a_wdata = wdata; a_mask = mask;
      qa.push_back('{d: ed, e: ee});
      @(posedge clk); #1;
      a_ren = 1'b0; a_wen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_ren = 0; a_wen = 0; a_addr = 0; a_wdata = 0; a_mask = 0;
      b_ren = 0; b_wen = 0; b_addr = 0; b_wdata = 0; b_mask = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_busy",   {31'd0, a_busy},   32'd0);
      chk("rst_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("rst_rdata",  a_rdata,           32'd0);
      chk("rst_error",  {31'd0, a_error},  32'd0);
      @(posedge clk); #1;

      // LATENCY=1 instance: writes then continuous reads, one response per cycle
      for (int i = 0; i < 3; i++) begin
         b_wen = 1'b1; b_addr = 32'(4 * i); b_wdata = 32'hA0A0_0000 + 32'(i); b_mask = 4'hF;
         qb.push_back('{d: 32'd0, e: 1'b0});
         @(posedge clk); #1;
         chk("b_busy_w", {31'd0, b_busy}, 32'd0);
      end
      b_wen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b_ren = 1'b1; b_addr = 32'(4 * i);
         qb.push_back('{d: 32'hA0A0_0000 + 32'(i), e: 1'b0});
         @(posedge clk); #1;
         chk("b_rvalid_c1", {31'd0, b_rvalid}, 32'd1);
         chk("b_busy_r",    {31'd0, b_busy},   32'd0);
      end
      b_ren = 1'b0;
      @(posedge clk); #1;
      chk("b_rvalid_idle", {31'd0, b_rvalid}, 32'd0);

      // LATENCY=2: full word write, busy in C+1, readback
      req_a(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
      chk("a_busy_c1", {31'd0, a_busy}, 32'd1);
      req_a(0, 1, 32'h00, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
      req_a(1, 0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0);

      // byte-lane write and masked reads
      req_a(0, 1, 32'h13, 32'hAB000000, 4'b1000, 32'd0, 1'b0);
      req_a(1, 0, 32'h10, 32'd0, 4'hF,    32'hABADBEEF, 1'b0);
      req_a(1, 0, 32'h10, 32'd0, 4'b0011, 32'h0000BEEF, 1'b0);

      // back-to-back: read presented in the write's RESP cycle
      req_a(0, 1, 32'h20, 32'h12345678, 4'hF, 32'd0, 1'b0);
      req_a(1, 0, 32'h20, 32'd0, 4'hF, 32'h12345678, 1'b0);
      chk("a_b2b_busy", {31'd0, a_busy}, 32'd1);
      a_wen = 1'b1; a_addr = 32'h20; a_wdata = 32'hFFFFFFFF; a_mask = 4'hF;
      @(posedge clk); #1;
      a_wen = 1'b0;
      req_a(1, 0, 32'h20, 32'd0, 4'hF, 32'h12345678, 1'b0);

      // zero mask is legal and inert
      req_a(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
      req_a(1, 0, 32'h20, 32'd0, 4'h0, 32'd0, 1'b0);
      req_a(1, 0, 32'h20, 32'd0, 4'hF, 32'h12345678, 1'b0);

      // error responses leave storage untouched
      req_a(1, 1, 32'h0,    32'h11111111, 4'hF, 32'd0, 1'b1);
      req_a(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1);
      req_a(1, 0, 32'h0,    32'd0, 4'hF, 32'hCAFEF00D, 1'b0);

      // async reset while a write is waiting
      req_a(0, 1, 32'h30, 32'h11112222, 4'hF, 32'd0, 1'b0);
      req_a(1, 0, 32'h30, 32'd0, 4'hF, 32'h11112222, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("a_rdata_hold", a_rdata, 32'h11112222);
      a_wen = 1'b1; a_addr = 32'h30; a_wdata = 32'h55555555; a_mask = 4'hF;
      @(posedge clk); #1;
      a_wen = 1'b0;
      chk("a_busy_pre_rst", {31'd0, a_busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy",   {31'd0, a_busy},   32'd0);
      chk("arst_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("arst_rdata",  a_rdata,           32'd0);
      chk("arst_error",  {31'd0, a_error},  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      req_a(1, 0, 32'h30, 32'd0, 4'hF, 32'h11112222, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      chk("a_queue_drained", 32'(qa.size()), 32'd0);
      chk("b_queue_drained", 32'(qb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
